// File: rtl/sdram_bist_engine_if.sv
// Request bus between the BIST master and sdram_core_32bit's inport_* side.
interface sdram_bist_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [3:0]        wr;
  logic              rd;
  logic [7:0]        len;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              accept;
  logic              ack;
  logic              error;
  logic [DATA_W-1:0] read_data;

  modport master (
    output wr, rd, len, addr, write_data,
    input  accept, ack, error, read_data
  );

  modport slave (
    input  wr, rd, len, addr, write_data,
    output accept, ack, error, read_data
  );
endinterface

// File: rtl/sdram_bist_engine.sv
// Write/read-back memory self-test master for the SDRAM core request bus.
// Define SDRAM_BIST_INV_PASS_EN to add a second pass with inverted-address data.
module sdram_bist_engine #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter int unsigned       NUM_WORDS = 1024,
  parameter int unsigned       ADDR_STEP = 4,
  parameter int unsigned       TIMEOUT   = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [15:0]         err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [DATA_W-1:0]   first_err_data_o,
  sdram_bist_engine_if.master outport
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
  } state_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_idx;
  logic [31:0]       r_tmo_cnt;
  logic              r_pass;
  logic              r_timeout;
  logic              r_err_seen;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic [DATA_W-1:0] r_first_err_data;

  logic [DATA_W-1:0] w_pattern;
  logic              w_last, w_tmo_hit;
  logic              w_start, w_step, w_rewind, w_fail, w_tmo, w_next_pass;

  always_comb begin
    w_pattern = DATA_W'(r_addr);
    if (r_pass) w_pattern = ~w_pattern;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_rewind     = 1'b0;
    w_fail       = 1'b0;
    w_tmo        = 1'b0;
    w_next_pass  = 1'b0;
    w_last       = (r_idx == 32'(NUM_WORDS - 1));
    w_tmo_hit    = (r_tmo_cnt >= 32'(TIMEOUT - 1));
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_next_state = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (outport.accept)  w_next_state = S_WR_WAIT;
        else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_WR_WAIT: begin
        if (outport.ack) begin
          w_fail = outport.error;
          if (w_last) begin
            w_rewind     = 1'b1;
            w_next_state = S_RD_REQ;
          end else begin
            w_step       = 1'b1;
            w_next_state = S_WR_REQ;
          end
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (outport.accept)  w_next_state = S_RD_WAIT;
        else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_RD_WAIT: begin
        if (outport.ack) begin
          w_fail = outport.error || (outport.read_data != w_pattern);
          if (w_last) begin
`ifdef SDRAM_BIST_INV_PASS_EN
            if (!r_pass) begin
              w_rewind     = 1'b1;
              w_next_pass  = 1'b1;
              w_next_state = S_WR_REQ;
            end else begin
              w_next_state = S_DONE;
            end
`else
            w_next_state = S_DONE;
`endif
          end else begin
            w_step       = 1'b1;
            w_next_state = S_RD_REQ;
          end
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr           <= '0;
      r_idx            <= '0;
      r_tmo_cnt        <= '0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_seen       <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else begin
      // Watchdog restarts on every state change, so it bounds each single wait.
      if (w_next_state != r_state || r_state == S_IDLE || r_state == S_DONE)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (w_start) begin
        r_addr           <= ADDR_BASE;
        r_idx            <= '0;
        r_pass           <= 1'b0;
        r_timeout        <= 1'b0;
        r_err_seen       <= 1'b0;
        r_err_count      <= '0;
        r_first_err_addr <= '0;
        r_first_err_data <= '0;
      end
      if (w_step) begin
        r_idx  <= r_idx + 32'd1;
        r_addr <= r_addr + ADDR_W'(ADDR_STEP);
      end
      if (w_rewind) begin
        r_idx  <= '0;
        r_addr <= ADDR_BASE;
      end
      if (w_next_pass) r_pass    <= 1'b1;
      if (w_tmo)       r_timeout <= 1'b1;
      if (w_fail) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (!r_err_seen) begin
          r_err_seen       <= 1'b1;
          r_first_err_addr <= r_addr;
          r_first_err_data <= outport.read_data;
        end
      end
    end
  end

  assign outport.wr         = (r_state == S_WR_REQ) ? 4'hF : 4'h0;
  assign outport.rd         = (r_state == S_RD_REQ);
  assign outport.len        = '0;
  assign outport.addr       = r_addr;
  assign outport.write_data = (r_state == S_WR_REQ) ? w_pattern : '0;

  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o           = (r_state == S_DONE);
  assign pass_o           = done_o && (r_err_count == 16'h0) && !r_timeout;
  assign timeout_o        = r_timeout;
  assign err_count_o      = r_err_count;
  assign first_err_addr_o = r_first_err_addr;
  assign first_err_data_o = r_first_err_data;

endmodule

// File: tb/tb_sdram_bist_engine.sv
// Scoreboard bench for sdram_bist_engine: a bus responder pops expected requests as they are issued.
`timescale 1ns/1ps
module tb_sdram_bist_engine;
  localparam int unsigned NW   = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass, tmo;
  logic [15:0] errc;
  logic [31:0] fea, fed;

  sdram_bist_engine_if #(.ADDR_W(32), .DATA_W(32)) bus();

  sdram_bist_engine #(
    .ADDR_W(32), .DATA_W(32), .ADDR_BASE(BASE), .NUM_WORDS(NW),
    .ADDR_STEP(4), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_count_o(errc), .first_err_addr_o(fea), .first_err_data_o(fed),
    .outport(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          accept_delay = 0;
  bit          ack_en = 1'b1;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  task automatic push_pass(input bit inv);
    req_t r;
    for (int i = 0; i < int'(NW); i++) begin
      r.is_rd = 1'b0;
      r.addr  = BASE + 32'(4 * i);
      r.data  = inv ? ~r.addr : r.addr;
      exp_q.push_back(r);
    end
    for (int i = 0; i < int'(NW); i++) begin
      r.is_rd = 1'b1;
      r.addr  = BASE + 32'(4 * i);
      r.data  = inv ? ~r.addr : r.addr;
      exp_q.push_back(r);
    end
  endtask

  task automatic push_test();
    push_pass(1'b0);
`ifdef SDRAM_BIST_INV_PASS_EN
    push_pass(1'b1);
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Responder + scoreboard; returns when done_o rises, the budget expires, or (optionally) a read is accepted.
  task automatic run_test(input int max_cycles, input bit abort_on_rd, output int cycles);
    bit          pending = 1'b0, pend_rd = 1'b0, waiting = 1'b0;
    logic [31:0] pend_addr = '0, s_addr = '0, s_data = '0;
    logic [3:0]  s_wr = '0;
    logic        s_rd = 1'b0;
    int          wait_cnt = 0;
    req_t        e;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      bus.accept = 1'b0;
      bus.ack    = 1'b0;
      bus.error  = 1'b0;
      if (done) return;
      if (cycles > max_cycles) begin
        vectors++;
        miscompares++;
        $display("FAIL run_budget: done_o=%0b after %0d cycles, required done_o=1", done, cycles);
        return;
      end
      if (pending) begin
        if (ack_en) begin
          bus.ack = 1'b1;
          pending = 1'b0;
          if (pend_rd) begin
            bus.read_data = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
            if (corrupt_en && pend_addr == corrupt_addr) begin
              bus.read_data = 32'hDEADBEEF;
              corrupt_en    = 1'b0;
            end
          end
        end
      end else if (bus.wr != 4'h0 || bus.rd) begin
        if (!waiting) begin
          waiting  = 1'b1;
          wait_cnt = 0;
          s_wr = bus.wr; s_rd = bus.rd; s_addr = bus.addr; s_data = bus.write_data;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_req: wr=%h rd=%0b addr=%h, required no request", s_wr, s_rd, s_addr);
          end else begin
            e = exp_q.pop_front();
            if ({s_rd, s_wr, s_addr, bus.len} !== {e.is_rd, (e.is_rd ? 4'h0 : 4'hF), e.addr, 8'h00}) begin
              miscompares++;
              $display("FAIL req_kind_addr: rd=%0b wr=%h addr=%h len=%h, required rd=%0b addr=%h len=00",
                       s_rd, s_wr, s_addr, bus.len, e.is_rd, e.addr);
            end
            if (!e.is_rd) begin
              vectors++;
              if (s_data !== e.data) begin
                miscompares++;
                $display("FAIL write_data @%h: got %h, required %h", e.addr, s_data, e.data);
              end
            end
          end
        end else begin
          vectors++;
          if ({bus.wr, bus.rd, bus.addr, bus.write_data} !== {s_wr, s_rd, s_addr, s_data}) begin
            miscompares++;
            $display("FAIL req_stable: wr=%h rd=%0b addr=%h data=%h, required wr=%h rd=%0b addr=%h data=%h",
                     bus.wr, bus.rd, bus.addr, bus.write_data, s_wr, s_rd, s_addr, s_data);
          end
        end
        if (wait_cnt >= accept_delay) begin
          bus.accept = 1'b1;
          pending    = 1'b1;
          pend_rd    = s_rd;
          pend_addr  = s_addr;
          waiting    = 1'b0;
          if (!s_rd) mem[s_addr] = s_data;
          if (abort_on_rd && s_rd) return;
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    bus.accept = 1'b0; bus.ack = 1'b0; bus.error = 1'b0; bus.read_data = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, pass, tmo} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status: busy/done/pass/timeout=%b, required 0000", {busy, done, pass, tmo});
    end
    vectors++;
    if ({errc, fea, fed} !== '0) begin
      miscompares++;
      $display("FAIL reset_err: count=%h addr=%h data=%h, required all 0", errc, fea, fed);
    end
    vectors++;
    if ({bus.wr, bus.rd, bus.len, bus.addr, bus.write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: wr=%h rd=%0b addr=%h data=%h, required all 0", bus.wr, bus.rd, bus.addr, bus.write_data);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%0b, required 0", busy);
    end
  endtask

  task automatic check_clean(input string name, input int cycles);
    vectors++;
    if ({done, pass, tmo, busy} !== 4'b1100) begin
      miscompares++;
      $display("FAIL %s_status: done/pass/timeout/busy=%b after %0d cycles, required 1100", name, {done, pass, tmo, busy}, cycles);
    end
    vectors++;
    if ({errc, fea, fed} !== '0) begin
      miscompares++;
      $display("FAIL %s_err: count=%h addr=%h data=%h, required all 0", name, errc, fea, fed);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_req_count: %0d expected requests never issued, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_ideal();
    int c;
    accept_delay = 0; ack_en = 1'b1;
    push_test();
    do_start();
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL ideal_busy: busy/done=%b, required 10", {busy, done});
    end
    run_test(200, 1'b0, c);
    check_clean("ideal", c);
  endtask

  task automatic test_corrupt_read();
    int c;
    accept_delay = 0; ack_en = 1'b1;
    corrupt_en = 1'b1; corrupt_addr = 32'h108;
    push_test();
    do_start();
    run_test(200, 1'b0, c);
    vectors++;
    if ({done, pass, tmo} !== 3'b100) begin
      miscompares++;
      $display("FAIL corrupt_status: done/pass/timeout=%b, required 100", {done, pass, tmo});
    end
    vectors++;
    if (errc !== 16'd1) begin
      miscompares++;
      $display("FAIL corrupt_count: got %0d, required 1", errc);
    end
    vectors++;
    if ({fea, fed} !== {32'h108, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL corrupt_first: addr=%h data=%h, required 00000108 deadbeef", fea, fed);
    end
  endtask

  task automatic test_slow_accept();
    int c;
    accept_delay = 5; ack_en = 1'b1;
    push_test();
    do_start();
    run_test(600, 1'b0, c);
    check_clean("slow_accept", c);
    accept_delay = 0;
  endtask

  task automatic test_timeout();
    int   c;
    req_t r;
    accept_delay = 0; ack_en = 1'b0;
    r.is_rd = 1'b0; r.addr = BASE; r.data = BASE;
    exp_q.push_back(r);
    do_start();
    run_test(40, 1'b0, c);
    vectors++;
    if ({done, tmo, pass, busy} !== 4'b1100) begin
      miscompares++;
      $display("FAIL timeout_status: done/timeout/pass/busy=%b, required 1100", {done, tmo, pass, busy});
    end
    vectors++;
    if (c + 1 > 20) begin
      miscompares++;
      $display("FAIL timeout_latency: done after %0d cycles, required <= 20", c + 1);
    end
    vectors++;
    if ({bus.wr, bus.rd} !== 5'b0) begin
      miscompares++;
      $display("FAIL timeout_bus: wr=%h rd=%0b, required 0 0", bus.wr, bus.rd);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_req_count: %0d expected requests never issued, required 0", exp_q.size());
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int c;
    accept_delay = 0; ack_en = 1'b1;
    push_test();
    do_start();
    run_test(200, 1'b1, c);
    @(negedge clk);
    bus.accept = 1'b0;
    vectors++;
    if ({busy, bus.rd, bus.wr} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rd_wait_state: busy=%0b rd=%0b wr=%h, required busy=1 rd=0 wr=0", busy, bus.rd, bus.wr);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, tmo, errc, fea, fed, bus.wr, bus.rd, bus.addr, bus.write_data} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: busy=%0b done=%0b wr=%h rd=%0b addr=%h errc=%h, required all 0",
               busy, done, bus.wr, bus.rd, bus.addr, errc);
    end
    rst = 1'b0;
    exp_q.delete();
    push_test();
    do_start();
    run_test(200, 1'b0, c);
    check_clean("after_reset", c);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt_read();
    test_slow_accept();
    test_timeout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
